// File: rtl/a2d_pkg.sv
// Shared types, channel numbers and SPI command layout for the A2D round-robin scheduler.
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, SEL, PAUSE, RD, UPD} state_t;

    typedef logic [1:0] rr_idx_t;

    localparam logic [2:0] CH_LFT_DEF   = 3'd0;
    localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
    localparam logic [2:0] CH_STEER_DEF = 3'd5;
    localparam logic [2:0] CH_BATT_DEF  = 3'd6;

    localparam int unsigned CMD_W      = 16;
    localparam int unsigned CMD_CH_LSB = 11;
    localparam int unsigned CMD_CH_W   = 3;
    localparam int unsigned RES_W      = 12;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [CMD_CH_W-1:0] ch);
        logic [CMD_W-1:0] cmd;
        cmd = '0;
        cmd[CMD_CH_LSB +: CMD_CH_W] = ch;
        return cmd;
    endfunction

endpackage

// File: rtl/a2d_result_bank.sv
// Four per-channel 12-bit result registers with a registered update strobe and index.
module a2d_result_bank
    import a2d_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  rr_idx_t          i_idx,
    input  logic [RES_W-1:0] i_data,
    output logic [RES_W-1:0] o_lft_ld,
    output logic [RES_W-1:0] o_rght_ld,
    output logic [RES_W-1:0] o_steer_pot,
    output logic [RES_W-1:0] o_batt,
    output logic             o_rd_vld,
    output rr_idx_t          o_rd_idx
);

    logic [RES_W-1:0] r_lft;
    logic [RES_W-1:0] r_rght;
    logic [RES_W-1:0] r_steer;
    logic [RES_W-1:0] r_batt;
    logic             r_rd_vld;
    rr_idx_t          r_rd_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lft    <= '0;
            r_rght   <= '0;
            r_steer  <= '0;
            r_batt   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= i_we;
            if (i_we) begin
                r_rd_idx <= i_idx;
                unique case (i_idx)
                    2'd0: r_lft   <= i_data;
                    2'd1: r_rght  <= i_data;
                    2'd2: r_steer <= i_data;
                    2'd3: r_batt  <= i_data;
                endcase
            end
        end
    end

    assign o_lft_ld    = r_lft;
    assign o_rght_ld   = r_rght;
    assign o_steer_pot = r_steer;
    assign o_batt      = r_batt;
    assign o_rd_vld    = r_rd_vld;
    assign o_rd_idx    = r_rd_idx;

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler: per trigger, a channel-select SPI transaction, a pause,
// then a read transaction whose 12-bit result lands in the per-channel holding register.
module a2d_rr_sched
    import a2d_pkg::*;
#(
    parameter int unsigned PAUSE_CYC = 2,
    parameter logic [2:0]  CH_LFT    = CH_LFT_DEF,
    parameter logic [2:0]  CH_RGHT   = CH_RGHT_DEF,
    parameter logic [2:0]  CH_STEER  = CH_STEER_DEF,
    parameter logic [2:0]  CH_BATT   = CH_BATT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_nxt,
    output logic             o_wrt,
    output logic [CMD_W-1:0] o_cmd,
    input  logic             i_done,
    input  logic [CMD_W-1:0] i_resp,
    output logic [RES_W-1:0] o_lft_ld,
    output logic [RES_W-1:0] o_rght_ld,
    output logic [RES_W-1:0] o_steer_pot,
    output logic [RES_W-1:0] o_batt,
    output logic             o_rd_vld,
    output rr_idx_t          o_rd_idx,
    output logic             o_busy,
    output logic             o_ovr
);

    localparam int unsigned CNT_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;

    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    rr_idx_t          r_ptr;
    rr_idx_t          w_ptr_d;
    logic [CMD_W-1:0] r_cmd;
    logic [CMD_W-1:0] w_cmd_d;
    logic             r_wrt;
    logic             w_wrt_d;
    logic             r_ovr;
    logic             w_ovr_d;
    logic             w_pause_wrt;
    logic             w_we;
    logic [2:0]       w_ch;
    logic             w_unused_resp;

    // ADC status nibble carries nothing we use
    assign w_unused_resp = ^i_resp[CMD_W-1:RES_W];

    always_comb begin
        w_ch = CH_LFT;
        unique case (r_ptr)
            2'd0: w_ch = CH_LFT;
            2'd1: w_ch = CH_RGHT;
            2'd2: w_ch = CH_STEER;
            2'd3: w_ch = CH_BATT;
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_ptr_d     = r_ptr;
        w_cmd_d     = r_cmd;
        w_wrt_d     = 1'b0;
        w_pause_wrt = 1'b0;
        w_we        = 1'b0;
        w_ovr_d     = r_ovr | (i_nxt & (r_state != IDLE));
        unique case (r_state)
            IDLE: begin
                if (i_nxt) begin
                    w_cmd_d   = make_cmd(w_ch);
                    w_wrt_d   = 1'b1;
                    w_state_d = SEL;
                end
            end
            SEL: begin
                // First response is the previously selected channel; drop it.
                if (i_done) begin
                    w_cnt_d   = CNT_W'(PAUSE_CYC - 1);
                    w_state_d = PAUSE;
                end
            end
            PAUSE: begin
                // Combinational strobe so the read starts exactly PAUSE_CYC after done.
                if (r_cnt == '0) begin
                    w_pause_wrt = 1'b1;
                    w_state_d   = RD;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            RD: begin
                if (i_done) begin
                    w_we      = 1'b1;
                    w_state_d = UPD;
                end
            end
            UPD: begin
                w_ptr_d   = r_ptr + 2'd1;
                w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_cmd   <= '0;
            r_wrt   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ptr   <= w_ptr_d;
            r_cmd   <= w_cmd_d;
            r_wrt   <= w_wrt_d;
            r_ovr   <= w_ovr_d;
        end
    end

    a2d_result_bank u_bank (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_we        (w_we),
        .i_idx       (r_ptr),
        .i_data      (i_resp[RES_W-1:0]),
        .o_lft_ld    (o_lft_ld),
        .o_rght_ld   (o_rght_ld),
        .o_steer_pot (o_steer_pot),
        .o_batt      (o_batt),
        .o_rd_vld    (o_rd_vld),
        .o_rd_idx    (o_rd_idx)
    );

    assign o_wrt  = r_wrt | w_pause_wrt;
    assign o_cmd  = r_cmd;
    assign o_busy = (r_state != IDLE);
    assign o_ovr  = r_ovr;

endmodule

// File: doc/a2d_rr_sched.md
Name: a2d_rr_sched

Overview:
- Round-robin conversion scheduler for the A2D converter: load cell left, load cell right, steering pot and battery.
- Sits between the Segway core and the existing SPI master. On each trigger it runs one two-transaction conversion for the next channel and latches the 12-bit result into a per-channel holding register.
- Downstream logic (rider detect, steer enable, battery/piezo warning) reads those registers.

Parameters:
- PAUSE_CYC, 2, idle clocks between the channel-select transaction's done and the read transaction's wrt (minimum 1).
- CH_LFT, 3'd0, A2D channel number for the left load cell.
- CH_RGHT, 3'd4, A2D channel number for the right load cell.
- CH_STEER, 3'd5, A2D channel number for the steering pot.
- CH_BATT, 3'd6, A2D channel number for the battery.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- nxt  in  1  one-cycle conversion trigger (inertial vld rate).
- wrt  out  1  one-cycle start pulse to SPI master.
- cmd  out  16  SPI command word.
- done  in  1  one-cycle SPI transaction-complete pulse.
- resp  in  16  SPI received word, valid while done=1.
- lft_ld  out  12  left load cell result.
- rght_ld  out  12  right load cell result.
- steer_pot  out  12  steering pot result.
- batt  out  12  battery result.
- rd_vld  out  1  one-cycle pulse when a result register updates.
- rd_idx  out  2  which register updated (0 lft, 1 rght, 2 steer, 3 batt); valid with rd_vld.
- busy  out  1  high from the wrt cycle to the result cycle inclusive.
- ovr  out  1  sticky: nxt arrived while busy.

Behaviour:
- Reset (sync, clk edge with rst=1) clears:
  - all outputs to 0;
  - the round-robin pointer to 0 (lft);
  - the pause counter; the state returns to IDLE.
- rst mid-conversion aborts at the next edge. wrt is never asserted in the cycle after rst. A late done from the aborted transfer is ignored because the state is IDLE.
- cmd encoding: {2'b00, ch[2:0], 11'h000}. ch is selected by the pointer (0→CH_LFT, 1→CH_RGHT, 2→CH_STEER, 3→CH_BATT). cmd is registered and held stable from the first wrt until the result cycle.
- States:
  - IDLE: wait for nxt. On nxt: latch cmd, assert wrt for 1 cycle → SEL.
  - SEL: wait for done; resp is discarded (the ADC returns the previous channel) → PAUSE with counter = PAUSE_CYC-1.
  - PAUSE: decrement; at 0, assert wrt for 1 cycle with the same cmd → RD.
  - RD: wait for done; capture resp[11:0] → UPD.
  - UPD: write the captured value to the register selected by the pointer; rd_vld=1, rd_idx=pointer; pointer increments mod 4 (3→0) → IDLE.
- Latency, counting the nxt cycle as cycle 0:
  - wrt is high in cycle 1;
  - the second wrt comes PAUSE_CYC cycles after the first done;
  - rd_vld comes exactly 1 cycle after the second done;
  - the result register shows the new value in the same cycle as rd_vld.
- busy is 1 in every state except IDLE.
- nxt while busy: the trigger is dropped (no queuing) and ovr is set; ovr clears only on rst. A nxt in the UPD cycle also counts as busy and is dropped.
- A nxt in the same cycle as rst is ignored.
- done outside SEL/RD is ignored.
- resp[15:12] are ignored.
- Result registers not being updated hold their value.
- Each result register holds its value until that channel is converted again.

Decomposition:
- Package a2d_pkg:
  - typedef enum state_t {IDLE, SEL, PAUSE, RD, UPD};
  - typedef logic [1:0] rr_idx_t;
  - localparams for the channel numbers and the cmd field positions.
- One sub-module, a2d_result_bank: four 12-bit registers with write-enable, index and sync reset. It also drives rd_vld/rd_idx registered from the write strobe.
- The FSM, pause counter and pointer stay in a2d_rr_sched.

Test Plan:
- Basic sequence. Reset, PAUSE_CYC=2, SPI model returns resp=16'h0356 for ch0. Pulse nxt → wrt at cycle 1 with cmd=16'h0000, second wrt exactly 2 cycles after the first done, then lft_ld=12'h356, rd_vld=1, rd_idx=0 one cycle after the second done.
- Round robin. Four nxt pulses, each spaced beyond the conversion time, with model values lft 12'h356, rght 12'h300, steer 12'h200, batt 12'h900 → cmds 16'h0000, 16'h2000, 16'h2800, 16'h3000 in order. All four registers hold those values. The fifth nxt issues cmd 16'h0000 again.
- Overrun. nxt pulsed during SEL and again in the UPD cycle → no extra wrt, ovr=1 and stays 1 through later conversions until rst.
- Reset mid-op. Assert rst during PAUSE → next cycle all outputs 0 and state IDLE. A done pulse arriving afterwards produces no rd_vld and no register change. The next nxt issues cmd 16'h0000.
- Upper bits masked. The model returns resp=16'hF9AB on the read → the targeted register = 12'h9AB, and no other register changes.
- Spurious done. done pulsed while in IDLE and while in PAUSE → no state change, no wrt, no rd_vld.
